// File: rtl/instruction_cache.sv
// Direct-mapped, read-only instruction cache in front of the fetch stage.
// Lookups are combinational from pc; a miss refills one whole line from
// instruction memory, one word per memValid beat, in ascending offset order.
//
// Refill handshake: while memRead is high, every rising edge with memValid=1
// consumes memData as the next word of the line (offset 0 first). memRead
// stays high through stalls and drops in the cycle after the last beat.
// memValid outside a refill is ignored.
module instruction_cache #(
    parameter int INDEX_BITS  = 4,
    parameter int OFFSET_BITS = 2
) (
    input  logic        clock,
    input  logic        resetN,
    input  logic [31:0] pc,
    input  logic        readEnable,
    input  logic        flush,
    output logic [31:0] instruction,
    output logic        hit,
    output logic        memRead,
    output logic [31:0] memAddress,
    input  logic [31:0] memData,
    input  logic        memValid,
    output logic        state_dbg
);

    localparam int LINES    = 1 << INDEX_BITS;
    localparam int WORDS    = 1 << OFFSET_BITS;
    localparam int LOW_BITS = OFFSET_BITS + 2;
    localparam int TAG_BITS = 32 - INDEX_BITS - LOW_BITS;
    localparam logic [OFFSET_BITS-1:0] LAST_BEAT = OFFSET_BITS'(WORDS - 1);

    // IDLE=0 performs lookups, REFILL=1 is fetching a line
    typedef enum logic {IDLE = 1'b0, REFILL = 1'b1} state_t;

    state_t                  state_q, state_d;
    logic [LINES-1:0]        valid_q, valid_d;
    logic [OFFSET_BITS-1:0]  beat_q, beat_d;
    logic                    discard_q, discard_d;
    logic                    mem_read_q, mem_read_d;
    logic [31:0]             mem_address_q, mem_address_d;
    logic [INDEX_BITS-1:0]   refill_index_q, refill_index_d;
    logic [TAG_BITS-1:0]     refill_tag_q, refill_tag_d;

    // Storage without reset: only the valid bits need a known value
    logic [TAG_BITS-1:0]     tag_q [LINES];
    logic [31:0]             data_q [LINES][WORDS];

    logic [OFFSET_BITS-1:0]  pc_offset;
    logic [INDEX_BITS-1:0]   pc_index;
    logic [TAG_BITS-1:0]     pc_tag;
    logic                    lookup_match;
    logic                    start_miss;
    logic                    beat_accept;
    logic                    line_done;
    logic                    unused_pc_low;

    assign pc_offset     = pc[LOW_BITS-1:2];
    assign pc_index      = pc[LOW_BITS+INDEX_BITS-1:LOW_BITS];
    assign pc_tag        = pc[31:LOW_BITS+INDEX_BITS];
    // Byte-within-word bits carry no meaning for a word-granular fetch
    assign unused_pc_low = ^pc[1:0];

    assign memRead    = mem_read_q;
    assign memAddress = mem_address_q;
    assign state_dbg  = (state_q == REFILL);

    // Same-cycle lookup; flush suppresses the hit and a miss alike
    always_comb begin
        lookup_match = valid_q[pc_index] && (tag_q[pc_index] == pc_tag);
        hit          = (state_q == IDLE) && readEnable && !flush && lookup_match;
        instruction  = hit ? data_q[pc_index][pc_offset] : 32'h0;
        start_miss   = (state_q == IDLE) && readEnable && !flush && !lookup_match;
    end

    // Next-state logic for the lookup/refill controller
    always_comb begin
        state_d        = state_q;
        valid_d        = valid_q;
        beat_d         = beat_q;
        discard_d      = discard_q;
        mem_read_d     = mem_read_q;
        mem_address_d  = mem_address_q;
        refill_index_d = refill_index_q;
        refill_tag_d   = refill_tag_q;
        beat_accept    = 1'b0;
        line_done      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_miss) begin
                    state_d        = REFILL;
                    mem_read_d     = 1'b1;
                    mem_address_d  = {pc[31:LOW_BITS], {LOW_BITS{1'b0}}};
                    refill_index_d = pc_index;
                    refill_tag_d   = pc_tag;
                    beat_d         = '0;
                    discard_d      = 1'b0;
                end
            end
            REFILL: begin
                // A flush mid-refill lets the line finish but never validates it
                if (flush) begin
                    discard_d = 1'b1;
                end
                if (memValid) begin
                    beat_accept = 1'b1;
                    beat_d      = beat_q + 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        line_done  = 1'b1;
                        state_d    = IDLE;
                        mem_read_d = 1'b0;
                        discard_d  = 1'b0;
                        if (!discard_q && !flush) begin
                            valid_d[refill_index_q] = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Flush wins over a simultaneous validation
        if (flush) begin
            valid_d = '0;
        end
    end

    // Controller state, valid bits and refill bookkeeping
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q        <= IDLE;
            valid_q        <= '0;
            beat_q         <= '0;
            discard_q      <= 1'b0;
            mem_read_q     <= 1'b0;
            mem_address_q  <= 32'h0;
            refill_index_q <= '0;
            refill_tag_q   <= '0;
        end else begin
            state_q        <= state_d;
            valid_q        <= valid_d;
            beat_q         <= beat_d;
            discard_q      <= discard_d;
            mem_read_q     <= mem_read_d;
            mem_address_q  <= mem_address_d;
            refill_index_q <= refill_index_d;
            refill_tag_q   <= refill_tag_d;
        end
    end

    // Line data and tag storage written by the refill
    always_ff @(posedge clock) begin
        if (beat_accept) begin
            data_q[refill_index_q][beat_q] <= memData;
        end
        if (line_done) begin
            tag_q[refill_index_q] <= refill_tag_q;
        end
    end

endmodule

// File: doc/instruction_cache.md
# instruction_cache

Direct-mapped, read-only instruction cache that sits directly upstream of the fetch stage. It serves the fetch stage's current PC with a same-cycle `instruction`/`hit` pair. On a miss it refills one whole line from instruction memory through a simple beat-valid interface, then resumes lookups.

## Interface
- `INDEX_BITS`, default 4: log2 of the number of lines (16 lines).
- `OFFSET_BITS`, default 2: log2 of the number of 32-bit words per line (4 words).
- `clock`  input  1  single clock; all state updates on the rising edge.
- `resetN`  input  1  asynchronous, active-low reset.
- `pc`  input  32  byte address from fetch; bits [1:0] ignored.
- `readEnable`  input  1  fetch requests a lookup this cycle.
- `flush`  input  1  synchronous invalidate-all.
- `instruction`  output  32  cached word for `pc`; 0 when `hit`=0.
- `hit`  output  1  `instruction` is valid this cycle.
- `memRead`  output  1  refill in progress (registered).
- `memAddress`  output  32  line-aligned refill address; low (OFFSET_BITS+2) bits are 0.
- `memData`  input  32  refill word.
- `memValid`  input  1  `memData` carries the next beat of the refill.

## Operation
- Address split (defaults): word offset = `pc`[3:2], index = `pc`[7:4], tag = `pc`[31:8].
- Storage: per line one valid bit, one tag of 32-INDEX_BITS-OFFSET_BITS-2 bits, and 2^OFFSET_BITS data words.
- States:
  - IDLE: the cache performs lookups.
  - REFILL: the cache is fetching a line.
- Outputs in IDLE:
  - `hit` = `readEnable` & valid[index] & (tag match).
  - `instruction` = data[index][offset] when `hit`=1, else 0.
- Miss: IDLE & `readEnable` & ~hit, with `flush`=0.
  - Next edge: latch line base into `memAddress`, latch index and tag, clear the beat counter, enter REFILL.
- REFILL:
  - `hit`=0 and `instruction`=0; `pc` and `readEnable` are ignored.
  - `memRead`=1 and `memAddress` is held constant.
  - Each edge with `memValid`=1 writes `memData` to word[beat counter] of the latched index, then increments the counter.
  - `memValid`=0 holds the counter.
  - When the last beat (counter = 2^OFFSET_BITS-1) is accepted: write the tag, set valid (unless discarded), return to IDLE.
- Beat order: memory returns words in ascending offset order starting at offset 0. `memValid` outside REFILL is ignored.
- Flush:
  - Clears all valid bits on the next edge.
  - In IDLE with `flush`=1: no miss is started and `hit` is forced to 0 that cycle.
  - In REFILL: a sticky discard flag is set. The refill runs to completion, but the line is left invalid and the flag is cleared on exit.
- Replacement is unconditional: the refilled line overwrites whatever occupied that index.

## Timing
- Reset (`resetN`=0, asynchronous): state IDLE, all valid bits 0, beat counter 0, discard flag 0, `memRead`=0, `memAddress`=0, `hit`=0, `instruction`=0. Data and tag arrays need no reset.
- Reset mid-refill: `memRead` drops immediately. The partial line stays invalid.
- Hit latency: 0 cycles (combinational from `pc`).
- Miss timeline:
  - Cycle 0: miss detected.
  - Edge 1: `memRead` rises with the address.
  - After N beats, edge N+1+gaps: back in IDLE, and `memRead`=0 that cycle.
  - The next cycle with the same `pc` hits.
- Minimum miss penalty with `memValid` stuck high: 2^OFFSET_BITS+1 cycles before the hit cycle.
- `memRead` is deasserted in the cycle after the last beat is accepted. Memory must not send beats beyond 2^OFFSET_BITS.
- Simultaneous `flush` and last beat: the line is not validated and all valid bits are cleared.

## Test plan
- Reset: assert `resetN`=0 with `readEnable`=1 and `pc`=0 -> `hit`=0, `instruction`=0, `memRead`=0. After release, the first lookup misses.
- Cold miss: `pc`=0x10; supply beats 0xA0,0xA1,0xA2,0xA3 back-to-back.
  - `memRead`=1 with `memAddress`=0x10 for exactly 4 cycles.
  - Then `pc`=0x10/0x14/0x1C -> `hit`=1 and `instruction`=0xA0/0xA1/0xA3 in the same cycle.
- Conflict: after the cold miss, `pc`=0x110 (same index 1, new tag) -> miss, refill with `memAddress`=0x110, then `hit`=1. Afterwards `pc`=0x10 -> `hit`=0 and a new refill starts.
- Stalled memory: `memValid` pattern 1,0,0,1,0,1,1 -> exactly 4 words written at offsets 0..3 in order. `memRead` stays high through the gaps and the address never changes.
- Flush:
  - Flush in IDLE after a valid line exists -> next lookup of that line misses.
  - Flush pulse during REFILL -> refill completes, then the same `pc` misses again.
- Async reset mid-refill after 2 beats -> `memRead`=0 without a clock edge. After release, `pc` of that line misses and refills from offset 0.
